i2c_reg_bridge: RTL
===================

// Module: i2c_reg_bridge
// PURPOSE
//  Register-map stage downstream of the I2C slave byte engine: consumes its received-byte AXI stream and feeds its transmit-byte stream.
//  First byte of each write transaction loads the register pointer; later bytes write registers with pointer auto-increment.
//  I2C reads stream register contents from the pointer, auto-incrementing. Exposes RW registers as a flat bus plus a write strobe.
// PARAMETERS
//  NUM_REGS  16  total register count; power of 2, 2..256
//  ADDR_W    4   pointer width, = log2(NUM_REGS)
//  RO_BASE   12  first read-only index; indices >= RO_BASE read ro_in and ignore writes (RO_BASE=NUM_REGS: none)
// PORTS
//  clk           in   1                   clock
//  rst_n         in   1                   asynchronous active-low reset
//  rx_tdata      in   8                   byte received from I2C slave
//  rx_tvalid     in   1                   rx byte valid
//  rx_tready     out  1                   rx byte accept
//  rx_tlast      in   1                   last byte of write transaction (stop/restart)
//  tx_tdata      out  8                   byte for I2C slave to transmit
//  tx_tvalid     out  1                   tx byte valid
//  tx_tready     in   1                   slave takes tx byte
//  tx_tlast      out  1                   always 0
//  ro_in         in   8*(NUM_REGS-RO_BASE) read-only values, index RO_BASE at bits [7:0]
//  reg_q         out  8*RO_BASE           RW register contents, reg 0 at bits [7:0]
//  reg_wr        out  1                   1-cycle pulse per RW register write
//  reg_wr_addr   out  ADDR_W              index written (valid with reg_wr)
//  reg_wr_data   out  8                   byte written (valid with reg_wr)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=PTR, ptr=0, all RW regs=0x00, rx_tready=0, tx_tvalid=0, tx_tdata=0x00, reg_wr=0, reg_wr_addr=0, reg_wr_data=0x00.
//  rx_tready=1 every cycle from the first clock after reset release; rx beat = rx_tvalid & rx_tready.
//  FSM on rx beats:
//   PTR : ptr <= rx_tdata[ADDR_W-1:0] (upper bits dropped); -> DATA if !rx_tlast, else stays PTR.
//   DATA: write rx_tdata to reg[ptr]; ptr <= ptr+1 mod NUM_REGS; -> PTR if rx_tlast, else stay DATA.
//  Write to ptr >= RO_BASE: data discarded, no reg_wr, ptr still increments.
//  RW write: reg_q updates and reg_wr pulses with addr/data in the cycle after the beat (1-cycle latency).
//  Tx path: tx_tdata is a holding register = view(ptr), view(i) = reg[i] if i<RO_BASE, else ro_in slot i.
//   Any rx beat or tx handshake -> tx_tvalid=0 next cycle (RELOAD); in RELOAD, tx_tdata <= view(new ptr); tx_tvalid=1 the cycle after.
//   tx_tvalid is forced low in any cycle with rx_tvalid=1; tx handshake cannot coincide with an rx beat.
//   tx handshake (tx_tvalid & tx_tready): ptr <= ptr+1 mod NUM_REGS; state unchanged.
//   tx_tdata is stable while tx_tvalid=1 and tx_tready=0; ro_in is sampled only at RELOAD.
//  After reset: first RELOAD in cycle 1 after release; tx_tvalid=1 from cycle 2 with view(0).
//  Wrap: ptr NUM_REGS-1 -> 0 on both paths.
//  Reset mid-transaction: all state returns to reset values immediately; a partial transaction is not resumed.
// TESTING
//  Write 0x03,0xA5,0x5A(tlast) -> reg3=0xA5, reg4=0x5A; two reg_wr pulses (addr 3, 4); state=PTR, ptr=5.
//  Write 0x02(tlast), then 3 tx handshakes with reg2..4=0x11,0x22,0x33 -> tx bytes 0x11,0x22,0x33; ptr=5.
//  Pointer 0x0F, write 0x01,0x02(tlast) -> reg15 RO: no strobe; reg0=0x02; ptr wraps to 1.
//  Pointer 0x1C (NUM_REGS=16) -> ptr=0xC; read returns ro_in slot 12 sampled at RELOAD.
//  tx_tready held 0 for 10 cycles while ro_in changes -> tx_tdata/tx_tvalid unchanged; byte taken on tready=1.
//  rst_n pulsed low in DATA after 1 byte -> outputs reset immediately; next rx byte is treated as pointer.

Source files
------------

// File: rtl/i2c_reg_bridge_if.sv
// Byte streams between the I2C slave byte engine and the register bridge.
// rx carries received bytes to the bridge, tx carries bytes back to the engine.
interface i2c_reg_bridge_if;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready;
  logic       rx_tlast;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;
  logic       tx_tlast;

  modport master (
    output rx_tdata,
    output rx_tvalid,
    output rx_tlast,
    input  rx_tready,
    input  tx_tdata,
    input  tx_tvalid,
    input  tx_tlast,
    output tx_tready
  );

  modport slave (
    input  rx_tdata,
    input  rx_tvalid,
    input  rx_tlast,
    output rx_tready,
    output tx_tdata,
    output tx_tvalid,
    output tx_tlast,
    input  tx_tready
  );
endinterface

// File: rtl/i2c_reg_bridge.sv
// Register map behind an I2C slave: pointer byte, then auto-incrementing
// register writes; reads stream registers from the pointer.
module i2c_reg_bridge #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int RO_BASE  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_reg_bridge_if.slave     bus,
  input  logic [8*((NUM_REGS > RO_BASE) ?
                 (NUM_REGS - RO_BASE) : 1)-1:0] ro_in,
  output logic [8*RO_BASE-1:0] reg_q,
  output logic                reg_wr,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [7:0]          reg_wr_data
);

  typedef enum logic {
    PTR,
    DATA
  } state_t;

  localparam logic [ADDR_W:0]   RO_LIM = (ADDR_W+1)'(RO_BASE);
  localparam logic [ADDR_W-1:0] ONE    = 1;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   ptr, ptr_d;
  logic                rdy;
  logic                reload, reload_d;
  logic                tv, tv_d;
  logic [7:0]          td, td_d;
  logic [8*RO_BASE-1:0] regs_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   wa_d;
  logic [7:0]          wd_d;
  logic [8*NUM_REGS-1:0] view;
  logic                beat;
  logic                hs;
  logic                ptr_rw;

  generate
    if (RO_BASE < NUM_REGS) begin : g_ro
      assign view = {ro_in, reg_q};
    end else begin : g_no_ro
      assign view = reg_q;
    end
  endgenerate

  assign bus.rx_tready = rdy;
  // tx is masked whenever rx is active so the two never handshake together
  assign bus.tx_tvalid = tv & ~bus.rx_tvalid;
  assign bus.tx_tdata  = td;
  assign bus.tx_tlast  = 1'b0;

  assign beat   = bus.rx_tvalid & rdy;
  assign hs     = bus.tx_tvalid & bus.tx_tready;
  assign ptr_rw = {1'b0, ptr} < RO_LIM;

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    regs_d   = reg_q;
    wr_d     = 1'b0;
    wa_d     = reg_wr_addr;
    wd_d     = reg_wr_data;
    // rdy is low only in the first cycle after reset: initial reload
    reload_d = beat | hs | ~rdy;
    tv_d     = (tv | reload) & ~(beat | hs);
    td_d     = reload ? view[{ptr, 3'b000} +: 8] : td;
    unique case (1'b1)
      beat && (state == PTR): begin
        ptr_d   = bus.rx_tdata[ADDR_W-1:0];
        state_d = bus.rx_tlast ? PTR : DATA;
      end
      beat && (state == DATA): begin
        if (ptr_rw) begin
          regs_d[{ptr, 3'b000} +: 8] = bus.rx_tdata;
          wr_d = 1'b1;
          wa_d = ptr;
          wd_d = bus.rx_tdata;
        end
        ptr_d = ptr + ONE;
        if (bus.rx_tlast) state_d = PTR;
      end
      hs: begin
        ptr_d = ptr + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PTR;
      ptr         <= '0;
      rdy         <= 1'b0;
      reload      <= 1'b0;
      tv          <= 1'b0;
      td          <= 8'h00;
      reg_q       <= '0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= 8'h00;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      rdy         <= 1'b1;
      reload      <= reload_d;
      tv          <= tv_d;
      td          <= td_d;
      reg_q       <= regs_d;
      reg_wr      <= wr_d;
      reg_wr_addr <= wa_d;
      reg_wr_data <= wd_d;
    end
  end

endmodule
